// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and types for the scoreboarded register file.
// Holds the default geometry, the default-width address/data typedefs and the
// address of the hardwired zero register.
package regfile_pkg;

    localparam int DATA_W_DEF = 64;
    localparam int DEPTH_DEF  = 32;
    localparam int NUM_RD_DEF = 2;
    localparam int ADDR_W_DEF = $clog2(DEPTH_DEF);

    typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
    typedef logic [DATA_W_DEF-1:0] reg_data_t;

    // Register that reads as zero and can never be reserved when ZERO_REG=1.
    localparam reg_addr_t ZERO_ADDR = '0;

endpackage

// File: rtl/regfile_sb_if.sv
// regfile_sb_if: bus bundle between decode/writeback logic (master) and the
// scoreboarded register file (slave). clk and rst stay outside the bundle.
interface regfile_sb_if
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int NUM_RD = NUM_RD_DEF
) ();

    localparam int ADDR_W = $clog2(DEPTH);

    // Read side: packed per port, port 0 in the LSBs.
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;

    // Writeback port.
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;

    // Issue-time reservation.
    logic                     rsv_en;
    logic [ADDR_W-1:0]        rsv_addr;

    // Number of registers currently awaiting writeback.
    logic [ADDR_W:0]          busy_cnt;

    modport master (
        output rd_addr,
        output wr_en,
        output wr_addr,
        output wr_data,
        output rsv_en,
        output rsv_addr,
        input  rd_data,
        input  rd_busy,
        input  busy_cnt
    );

    modport slave (
        input  rd_addr,
        input  wr_en,
        input  wr_addr,
        input  wr_data,
        input  rsv_en,
        input  rsv_addr,
        output rd_data,
        output rd_busy,
        output busy_cnt
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: pending-write tracker for the register file.
// One pending bit per register: set by a reserve, cleared by a write, with the
// reserve winning when both hit the same register on the same edge. Register 0
// is never tracked when ZERO_REG=1. busy_cnt is the registered population
// count of the pending vector, updated on the same edge as the vector itself.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter  int DEPTH    = DEPTH_DEF,
    parameter  int ZERO_REG = 1,
    localparam int ADDR_W   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic [DEPTH-1:0]  pending,
    output logic [ADDR_W:0]   busy_cnt
);

    logic [DEPTH-1:0] pending_reg;
    logic [DEPTH-1:0] pending_next;
    logic [ADDR_W:0]  busy_cnt_reg;
    logic [ADDR_W:0]  busy_cnt_next;
    logic             wr_ok;
    logic             rsv_ok;

    // Accesses aimed at the hardwired zero register leave the scoreboard alone.
    assign wr_ok  = wr_en  && !((ZERO_REG != 0) && (wr_addr  == ADDR_W'(ZERO_ADDR)));
    assign rsv_ok = rsv_en && !((ZERO_REG != 0) && (rsv_addr == ADDR_W'(ZERO_ADDR)));

    // Next pending vector: clear on writeback first, then set on reserve so a
    // same-register collision leaves the bit set.
    always_comb begin
        pending_next = pending_reg;
        if (wr_ok) begin
            pending_next[wr_addr] = 1'b0;
        end
        if (rsv_ok) begin
            pending_next[rsv_addr] = 1'b1;
        end
    end

    // Population count of the next vector so the registered count tracks it exactly.
    always_comb begin
        busy_cnt_next = '0;
        for (int i = 0; i < DEPTH; i++) begin
            busy_cnt_next = busy_cnt_next + (ADDR_W+1)'(pending_next[i]);
        end
    end

    // Scoreboard state: asynchronously cleared, abandoning any outstanding reservations.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_reg  <= '0;
            busy_cnt_reg <= '0;
        end else begin
            pending_reg  <= pending_next;
            busy_cnt_reg <= busy_cnt_next;
        end
    end

    assign pending  = pending_reg;
    assign busy_cnt = busy_cnt_reg;

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: general-purpose register file with built-in write scoreboard.
// NUM_RD combinational read ports, one synchronous write port, one reserve
// port. Each read port reports the pending bit of its addressed register so
// decode can stall on RAW hazards.
// Optional feature: define REGFILE_BYPASS_EN to forward the write port to any
// read port addressing the register being written in the same cycle.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter  int DATA_W   = DATA_W_DEF,
    parameter  int DEPTH    = DEPTH_DEF,
    parameter  int NUM_RD   = NUM_RD_DEF,
    parameter  int ZERO_REG = 1,
    localparam int ADDR_W   = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    regfile_sb_if.slave bus
);

    logic [DATA_W-1:0] mem_reg [DEPTH];
    logic [DEPTH-1:0]  pending;
    logic              wr_ok;
    logic [DATA_W-1:0] rd_data_w [NUM_RD];
    logic [NUM_RD-1:0] rd_busy_w;

    // Register 0 is never written when it is hardwired to zero.
    assign wr_ok = bus.wr_en && !((ZERO_REG != 0) && (bus.wr_addr == ADDR_W'(ZERO_ADDR)));

    // Register array: cleared asynchronously so reads return zero while rst is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (wr_ok) begin
            mem_reg[bus.wr_addr] <= bus.wr_data;
        end
    end

    regfile_scoreboard #(
        .DEPTH    (DEPTH),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (bus.wr_en),
        .wr_addr  (bus.wr_addr),
        .rsv_en   (bus.rsv_en),
        .rsv_addr (bus.rsv_addr),
        .pending  (pending),
        .busy_cnt (bus.busy_cnt)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [ADDR_W-1:0] addr;
            logic              is_zero;
            logic              fwd;
            logic              fwd_busy;

            assign addr    = bus.rd_addr[gi*ADDR_W +: ADDR_W];
            assign is_zero = (ZERO_REG != 0) && (addr == ADDR_W'(ZERO_ADDR));

`ifdef REGFILE_BYPASS_EN
            // Forward the in-flight write; the register then only looks busy
            // if it is being re-reserved on the same edge. Forwarding is held
            // off during reset so every port reads zero.
            assign fwd      = !rst && bus.wr_en && (bus.wr_addr == addr) && !is_zero;
            assign fwd_busy = bus.rsv_en && (bus.rsv_addr == addr);
`else
            assign fwd      = 1'b0;
            assign fwd_busy = 1'b0;
`endif

            assign rd_data_w[gi] = fwd ? bus.wr_data : (is_zero ? '0 : mem_reg[addr]);
            assign rd_busy_w[gi] = fwd ? fwd_busy : (!is_zero && pending[addr]);
        end
    endgenerate

    // Pack per-port read data onto the bus, port 0 in the LSBs.
    always_comb begin
        bus.rd_data = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            bus.rd_data[i*DATA_W +: DATA_W] = rd_data_w[i];
        end
    end

    assign bus.rd_busy = rd_busy_w;

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed vector table, a hand-written reset sequence and a
// randomized run, all checked against a behavioural register/pending model.
module tb_regfile_sb;
    import regfile_pkg::*;

    localparam int DW  = 64;
    localparam int DEP = 32;
    localparam int NR  = 2;
    localparam int AW  = 5;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    localparam logic [63:0] C31 = 64'h0123_4567_89AB_CDEF;

    typedef struct {
        logic          wr_en;
        logic [AW-1:0] wr_addr;
        logic [DW-1:0] wr_data;
        logic          rsv_en;
        logic [AW-1:0] rsv_addr;
        logic [AW-1:0] ra0;
        logic [AW-1:0] ra1;
        logic [DW-1:0] ed0;
        logic [DW-1:0] ed1;
        logic          eb0;
        logic          eb1;
        logic [AW:0]   ecnt;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_sb_if #(.DATA_W(DW), .DEPTH(DEP), .NUM_RD(NR)) bus ();

    regfile_sb #(
        .DATA_W   (DW),
        .DEPTH    (DEP),
        .NUM_RD   (NR),
        .ZERO_REG (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: register contents and pending flags.
    logic [DW-1:0] m_mem  [DEP];
    bit            m_pend [DEP];

    vec_t vecs [19];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < DEP; i++) begin
            m_mem[i]  = '0;
            m_pend[i] = 1'b0;
        end
    endfunction

    function automatic logic [DW-1:0] model_data(input vec_t v, input logic [AW-1:0] a);
        if (a == 0) return '0;
        if (BYP && v.wr_en && v.wr_addr == a) return v.wr_data;
        return m_mem[a];
    endfunction

    function automatic logic model_busy(input vec_t v, input logic [AW-1:0] a);
        if (a == 0) return 1'b0;
        if (BYP && v.wr_en && v.wr_addr == a) return v.rsv_en && (v.rsv_addr == a);
        return m_pend[a];
    endfunction

    function automatic logic [AW:0] model_cnt();
        int n = 0;
        for (int i = 0; i < DEP; i++) n += int'(m_pend[i]);
        return (AW+1)'(n);
    endfunction

    // One clock edge: write clears, reserve sets afterwards, register 0 untouched.
    function automatic void model_step(input vec_t v);
        if (v.wr_en && v.wr_addr != 0) begin
            m_mem[v.wr_addr]  = v.wr_data;
            m_pend[v.wr_addr] = 1'b0;
        end
        if (v.rsv_en && v.rsv_addr != 0) m_pend[v.rsv_addr] = 1'b1;
    endfunction

    function automatic vec_t mk(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                                input logic re, input logic [AW-1:0] ra,
                                input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                                input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                                input logic b0, input logic b1, input logic [AW:0] c);
        vec_t v;
        v.wr_en = we; v.wr_addr = wa; v.wr_data = wd;
        v.rsv_en = re; v.rsv_addr = ra;
        v.ra0 = a0; v.ra1 = a1;
        v.ed0 = d0; v.ed1 = d1; v.eb0 = b0; v.eb1 = b1; v.ecnt = c;
        return v;
    endfunction

    // Drive one transaction (entered just after a rising edge), check the
    // outputs before the next edge, then advance the model across that edge.
    task automatic run_vec(input vec_t v, input bit use_table, input string tag);
        logic [DW-1:0] e0, e1;
        logic          b0, b1;
        logic [AW:0]   c;
        bus.wr_en    = v.wr_en;
        bus.wr_addr  = v.wr_addr;
        bus.wr_data  = v.wr_data;
        bus.rsv_en   = v.rsv_en;
        bus.rsv_addr = v.rsv_addr;
        bus.rd_addr  = {v.ra1, v.ra0};
        #1;
        if (use_table) begin
            e0 = v.ed0; e1 = v.ed1; b0 = v.eb0; b1 = v.eb1; c = v.ecnt;
        end else begin
            e0 = model_data(v, v.ra0); e1 = model_data(v, v.ra1);
            b0 = model_busy(v, v.ra0); b1 = model_busy(v, v.ra1);
            c  = model_cnt();
        end
        $display("%s wr=%0b r%0d=%h rsv=%0b r%0d | p0 r%0d=%h b%0b p1 r%0d=%h b%0b cnt=%0d",
                 tag, v.wr_en, v.wr_addr, v.wr_data, v.rsv_en, v.rsv_addr,
                 v.ra0, bus.rd_data[63:0], bus.rd_busy[0],
                 v.ra1, bus.rd_data[127:64], bus.rd_busy[1], bus.busy_cnt);
        chk({tag, "_rd_data0"}, bus.rd_data[63:0], e0);
        chk({tag, "_rd_data1"}, bus.rd_data[127:64], e1);
        chk({tag, "_rd_busy0"}, 64'(bus.rd_busy[0]), 64'(b0));
        chk({tag, "_rd_busy1"}, 64'(bus.rd_busy[1]), 64'(b1));
        chk({tag, "_busy_cnt"}, 64'(bus.busy_cnt), 64'(c));
        @(posedge clk);
        model_step(v);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;

        // Directed table: expectations hold before each vector's edge.
        vecs[0]  = mk(1, 31, C31, 0, 0, 31, 31, BYP ? C31 : 64'h0, BYP ? C31 : 64'h0, 0, 0, 0);
        vecs[1]  = mk(0, 0, 0, 0, 0, 31, 31, C31, C31, 0, 0, 0);
        vecs[2]  = mk(0, 0, 0, 1, 3, 3, 3, 0, 0, 0, 0, 0);
        vecs[3]  = mk(0, 0, 0, 0, 0, 3, 3, 0, 0, 1, 1, 1);
        vecs[4]  = mk(1, 3, 64'h55, 0, 0, 3, 3, BYP ? 64'h55 : 64'h0, BYP ? 64'h55 : 64'h0,
                      !BYP, !BYP, 1);
        vecs[5]  = mk(0, 0, 0, 0, 0, 3, 3, 64'h55, 64'h55, 0, 0, 0);
        vecs[6]  = mk(1, 9, 64'hAA, 1, 9, 9, 9, BYP ? 64'hAA : 64'h0, BYP ? 64'hAA : 64'h0,
                      BYP, BYP, 0);
        vecs[7]  = mk(0, 0, 0, 0, 0, 9, 9, 64'hAA, 64'hAA, 1, 1, 1);
        vecs[8]  = mk(0, 0, 0, 1, 9, 9, 9, 64'hAA, 64'hAA, 1, 1, 1);
        vecs[9]  = mk(0, 0, 0, 1, 9, 9, 9, 64'hAA, 64'hAA, 1, 1, 1);
        vecs[10] = mk(1, 9, 64'hBB, 0, 0, 9, 9, BYP ? 64'hBB : 64'hAA, BYP ? 64'hBB : 64'hAA,
                      !BYP, !BYP, 1);
        vecs[11] = mk(0, 0, 0, 0, 0, 9, 9, 64'hBB, 64'hBB, 0, 0, 0);
        vecs[12] = mk(1, 0, 64'hFF, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[14] = mk(1, 4, 64'h11, 0, 0, 31, 4, C31, BYP ? 64'h11 : 64'h0, 0, 0, 0);
        vecs[15] = mk(1, 4, 64'h77, 0, 0, 31, 4, C31, BYP ? 64'h77 : 64'h11, 0, 0, 0);
        vecs[16] = mk(0, 0, 0, 0, 0, 31, 4, C31, 64'h77, 0, 0, 0);
        vecs[17] = mk(1, 12, 64'h1234, 1, 13, 12, 13, BYP ? 64'h1234 : 64'h0, 0, 0, 0, 0);
        vecs[18] = mk(0, 0, 0, 0, 0, 12, 13, 64'h1234, 0, 0, 1, 1);

        // Power-on reset: everything reads zero while rst is high.
        rst = 1'b1;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.rsv_en = 1'b0; bus.rsv_addr = '0;
        bus.rd_addr = {5'd31, 5'd5};
        model_reset();
        @(posedge clk);
        #1;
        chk("por_rd_data0", bus.rd_data[63:0], 64'h0);
        chk("por_rd_data1", bus.rd_data[127:64], 64'h0);
        chk("por_rd_busy", 64'(bus.rd_busy), 64'h0);
        chk("por_busy_cnt", 64'(bus.busy_cnt), 64'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 19; i++) begin
            run_vec(vecs[i], 1'b1, $sformatf("vec%0d", i));
        end

        // Mid-run reset discards data and reservations immediately.
        run_vec(mk(1, 5, 64'hDEAD, 0, 0, 5, 7, 0, 0, 0, 0, 0), 1'b0, "pre_rst_wr");
        run_vec(mk(0, 0, 0, 1, 7, 5, 7, 0, 0, 0, 0, 0), 1'b0, "pre_rst_rsv");
        run_vec(mk(0, 0, 0, 0, 0, 5, 7, 0, 0, 0, 0, 0), 1'b0, "pre_rst_idle");
        bus.wr_en = 1'b1; bus.wr_addr = 5'd6; bus.wr_data = 64'h66;
        bus.rsv_en = 1'b1; bus.rsv_addr = 5'd8;
        bus.rd_addr = {5'd7, 5'd5};
        #1;
        rst = 1'b1;
        #1;
        $display("rst_async p0 r5=%h p1 r7 b%0b cnt=%0d", bus.rd_data[63:0], bus.rd_busy[1], bus.busy_cnt);
        chk("rst_r5_data", bus.rd_data[63:0], 64'h0);
        chk("rst_r7_data", bus.rd_data[127:64], 64'h0);
        chk("rst_r7_busy", 64'(bus.rd_busy[1]), 64'h0);
        chk("rst_busy_cnt", 64'(bus.busy_cnt), 64'h0);
        @(posedge clk);
        #1;
        $display("rst_edge wr r6 rsv r8 during reset cnt=%0d", bus.busy_cnt);
        chk("rst_edge_busy_cnt", 64'(bus.busy_cnt), 64'h0);
        bus.wr_en = 1'b0;
        bus.rsv_en = 1'b0;
        rst = 1'b0;
        model_reset();
        run_vec(mk(0, 0, 0, 0, 0, 6, 8, 0, 0, 0, 0, 0), 1'b1, "post_rst");
        run_vec(mk(0, 0, 0, 0, 0, 5, 7, 0, 0, 0, 0, 0), 1'b1, "post_rst2");

        // Randomized traffic, addresses biased towards a few registers for collisions.
        for (int n = 0; n < 400; n++) begin
            v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            v.wr_en    = 1'($urandom_range(0, 1));
            v.wr_addr  = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 7));
            v.wr_data  = {$urandom, $urandom};
            v.rsv_en   = 1'($urandom_range(0, 1));
            v.rsv_addr = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 7));
            v.ra0      = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 7));
            v.ra1      = ($urandom_range(0, 1) == 0) ? v.wr_addr : AW'($urandom_range(0, 7));
            run_vec(v, 1'b0, $sformatf("rnd%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
